// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed scan of an NDIG-digit display with blanking gaps
// and a frame-synchronous double-buffered display word. Rev 1.0
`default_nettype none

module seven_seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int BLANK = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [4*NDIG-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [NDIG-1:0]   anode_n,
  output logic [3:0]        nibble,
  output logic              frame_done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NDIG - 1);
  localparam logic [15:0]   DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0]   BLANK_LAST = 16'((BLANK == 0) ? 0 : BLANK - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BLANK = 2'd1, S_SHOW = 2'd2} state_t;

  // Phase that opens every digit: skip the blank gap when it is configured to zero
  localparam state_t FIRST_PH = (BLANK == 0) ? S_SHOW : S_BLANK;

  state_t              state, state_d;
  logic [IW-1:0]       idx, idx_d;
  logic [15:0]         cnt, cnt_d;
  logic [4*NDIG-1:0]   display, pending;
  logic                pflag;
  logic [NDIG-1:0]     anode_d;
  logic [3:0]          nibble_d;
  logic                fd_d;
  logic                show_end, frame_end, accept, commit;

  assign data_ready = ~pflag;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cnt_d    = cnt + 16'd1;
    anode_d  = '1;
    nibble_d = 4'd0;
    show_end  = (state == S_SHOW) && (cnt == DWELL_LAST);
    frame_end = show_end && (idx == LAST_IDX);
    accept    = data_valid && !pflag;
    // A dark display may take the new word at once; a running one waits for the frame end
    commit    = pflag && ((enable && frame_end) || (!enable && state == S_IDLE));
    fd_d      = enable && frame_end;

    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_d = FIRST_PH;
          idx_d   = '0;
          cnt_d   = 16'd0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = 16'd0;
          end
        end
        S_SHOW: begin
          if (show_end) begin
            state_d = FIRST_PH;
            cnt_d   = 16'd0;
            idx_d   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = 16'd0;
        end
      endcase
    end

    if (enable && state == S_SHOW) begin
      anode_d[idx] = 1'b0;
      nibble_d     = display[{idx, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= 16'd0;
      display    <= '0;
      pending    <= '0;
      pflag      <= 1'b0;
      anode_n    <= '1;
      nibble     <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      anode_n    <= anode_d;
      nibble     <= nibble_d;
      frame_done <= fd_d;
      if (accept) begin
        pending <= data_in;
        pflag   <= 1'b1;
      end else if (commit) begin
        display <= pending;
        pflag   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed stimulus with a queued-expectation scoreboard.
`default_nettype none

module tb_seven_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [1:0] anode_n;
  logic [3:0] nibble;
  logic       frame_done;

  seven_seg_scan_ctrl #(.NDIG(2), .DWELL(4), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .anode_n    (anode_n),
    .nibble     (nibble),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] an;
    logic [3:0] nib;
    logic       rdy;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Monitor: each expectation describes the outputs just after the following rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (anode_n !== e.an || nibble !== e.nib || data_ready !== e.rdy || frame_done !== e.fd) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got an=%b nib=%h rdy=%b fd=%b, expected an=%b nib=%h rdy=%b fd=%b",
                   vectors, $time, anode_n, nibble, data_ready, frame_done, e.an, e.nib, e.rdy, e.fd);
        end
      end
    end
  end

  task automatic step(input logic en, input logic v, input logic [7:0] d,
                      input logic [1:0] an, input logic [3:0] nib, input logic rdy, input logic fd);
    exp_t e;
    @(negedge clk);
    enable     = en;
    data_valid = v;
    data_in    = d;
    e.an = an; e.nib = nib; e.rdy = rdy; e.fd = fd;
    q.push_back(e);
  endtask

  // One enabled frame (12 cycles for NDIG=2, BLANK=2, DWELL=4), optionally cut short at nj.
  // Words are offered at steps vj1/vj2; ready is expected low for steps r0..r1-1.
  task automatic frame(input logic [3:0] n0, input logic [3:0] n1, input int nj,
                       input int vj1, input logic [7:0] d1, input int vj2, input logic [7:0] d2,
                       input int r0, input int r1);
    for (int j = 1; j <= nj; j++) begin
      logic [1:0] an;
      logic [3:0] nb;
      logic [7:0] dv;
      an = 2'b11;
      nb = 4'h0;
      if (j >= 3 && j <= 6) begin
        an = 2'b10;
        nb = n0;
      end else if (j >= 9) begin
        an = 2'b01;
        nb = n1;
      end
      dv = (j == vj1) ? d1 : ((j == vj2) ? d2 : 8'h00);
      step(1'b1, (j == vj1) || (j == vj2), dv, an, nb, !(j >= r0 && j < r1), j == 12);
    end
  endtask

  initial begin : stimulus
    rst_n      = 1'b0;
    enable     = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state held while disabled
    repeat (10) step(1'b0, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);

    // Load while dark commits immediately, then scan A5
    step(1'b0, 1'b1, 8'hA5, 2'b11, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);
    frame(4'h5, 4'hA, 12, 0, 8'h00, 0, 8'h00, 99, 99);

    // Mid-frame word 3C accepted, FF offered while busy is ignored
    frame(4'h5, 4'hA, 12, 4, 8'h3C, 6, 8'hFF, 4, 12);
    // Word 71 offered on the frame-end cycle waits one whole frame
    frame(4'hC, 4'h3, 12, 12, 8'h71, 0, 8'h00, 12, 13);
    frame(4'hC, 4'h3, 12, 0, 8'h00, 0, 8'h00, 1, 12);
    frame(4'h1, 4'h7, 12, 0, 8'h00, 0, 8'h00, 99, 99);

    // Enable dropped during digit 1, then restart from a blank gap
    frame(4'h1, 4'h7, 9, 0, 8'h00, 0, 8'h00, 99, 99);
    repeat (3) step(1'b0, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);
    frame(4'h1, 4'h7, 12, 0, 8'h00, 0, 8'h00, 99, 99);

    // Asynchronous reset mid-SHOW with a word pending
    frame(4'h1, 4'h7, 4, 2, 8'h99, 0, 8'h00, 2, 99);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    enable = 1'b0;
    data_valid = 1'b0;
    #1;
    vectors++;
    if (anode_n !== 2'b11 || nibble !== 4'h0 || data_ready !== 1'b1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset @%0t: got an=%b nib=%h rdy=%b fd=%b, expected an=11 nib=0 rdy=1 fd=0",
               $time, anode_n, nibble, data_ready, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 2'b11, 4'h0, 1'b1, 1'b0);
    frame(4'h0, 4'h0, 12, 0, 8'h00, 0, 8'h00, 99, 99);
    frame(4'h0, 4'h0, 12, 0, 8'h00, 0, 8'h00, 99, 99);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
